// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and the legality/alignment check
// for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_READ,
    WRITE,
    RESP
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // True when the request is both a legal encoding and naturally aligned.
  function automatic logic is_legal(input logic we, input logic [2:0] funct3,
                                    input logic [1:0] offset);
    logic ok;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~offset[0];
      F3_W:    ok = (offset == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~offset[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_rmw_if.sv
// Core request/response and data-memory signals of the load/store unit.
interface lsu_rmw_if #(parameter int ADDR_W = 10);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wd;
  logic [31:0]       mem_rd;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wd
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: extracts and extends load data, and merges
// sub-word store data into a full word.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b   = word[{offset, 3'b000} +: 8];
    lane_h   = offset[1] ? word[31:16] : word[15:0];
    load_val = '0;
    merged   = word;
    case (funct3)
      F3_B: begin
        load_val = {{24{lane_b[7]}}, lane_b};
        merged[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      F3_BU: load_val = {24'b0, lane_b};
      F3_H: begin
        load_val = {{16{lane_h[15]}}, lane_h};
        merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      end
      F3_HU: load_val = {16'b0, lane_h};
      F3_W: begin
        load_val = word;
        merged   = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit: maps RV32I byte/half/word accesses onto a word-only
// memory, using read-modify-write for sub-word stores.
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10
)
(
  input logic       clk,
  input logic       rst_n,
  lsu_rmw_if.slave  bus
);

  lsu_state_t        state, state_next;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q, buf_q, rdata_q;
  logic              err_q;
  logic [31:0]       lane_word, load_val, merged;
  logic              accept, legal;

  assign accept    = (state == IDLE) && bus.req_valid;
  assign legal     = is_legal(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
  // LOAD extracts straight from memory; WRITE merges into the captured word.
  assign lane_word = (state == LOAD) ? bus.mem_rd : buf_q;

  lsu_byte_lane u_lane (
    .word     (lane_word),
    .offset   (off_q),
    .funct3   (f3_q),
    .wdata    (wdata_q),
    .load_val (load_val),
    .merged   (merged)
  );

  always_comb begin
    state_next     = state;
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = (state == RESP);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
    bus.mem_we     = (state == WRITE);
    bus.mem_addr   = waddr_q;
    bus.mem_wd     = (state == WRITE) ? merged : 32'h0;
    case (state)
      IDLE: if (bus.req_valid) begin
        if (!legal)                           state_next = RESP;
        else if (!bus.req_we)                 state_next = LOAD;
        else if (bus.req_funct3 == F3_W)      state_next = WRITE;
        else                                  state_next = RMW_READ;
      end
      LOAD:     state_next = RESP;
      RMW_READ: state_next = WRITE;
      WRITE:    state_next = RESP;
      RESP:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b0;
      off_q   <= 2'b0;
      waddr_q <= '0;
      wdata_q <= 32'h0;
      buf_q   <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        off_q   <= bus.req_addr[1:0];
        waddr_q <= bus.req_addr[ADDR_W+1:2];
        wdata_q <= bus.req_wdata;
      end
      if (state == RMW_READ) buf_q <= bus.mem_rd;
      // Response registers change only on the edge that enters RESP.
      if (accept && !legal) begin
        err_q   <= 1'b1;
        rdata_q <= 32'h0;
      end
      if (state == LOAD) begin
        err_q   <= 1'b0;
        rdata_q <= load_val;
      end
      if (state == WRITE) begin
        err_q   <= 1'b0;
        rdata_q <= 32'h0;
      end
    end
  end

endmodule

// File: doc/lsu_rmw.md
# lsu_rmw

Load/store unit that sits between the RISC-V core's memory stage and the word-wide data memory. It turns RV32I byte, halfword and word loads and stores into word accesses on the data memory port. Sub-word stores use read-modify-write, because the data memory has one write enable and no byte strobes. Loads are sign- or zero-extended, and misaligned or illegal requests return an error without touching memory.

## Interface
Parameters:
- ADDR_W, 10, word-address width of the data memory (1024 words).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  core request present.
- req_ready  out  1  unit idle; a request is accepted when req_valid and req_ready are both 1 at a rising edge.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal request, qualified by resp_valid.
- mem_we  out  1  data-memory write enable.
- mem_addr  out  ADDR_W  word address.
- mem_wd  out  32  write data.
- mem_rd  in  32  combinational read data for mem_addr.

## Operation
- States: IDLE, LOAD, RMW_READ, WRITE, RESP.
- On acceptance in IDLE, latch req_we, req_funct3, req_addr[1:0], req_addr[ADDR_W+1:2] and req_wdata. Upper address bits are ignored, so addresses wrap.
- Illegal requests:
  - funct3 011, 110 or 111 for either loads or stores.
  - funct3 100 or 101 on a store.
- Misaligned requests:
  - H/HU with addr[0]=1.
  - W with addr[1:0]≠0.
- Illegal or misaligned: IDLE→RESP with resp_err=1, no memory access.
- Load: IDLE→LOAD→RESP.
  - In LOAD, select the byte/halfword lane from mem_rd by addr[1:0], then sign-extend (B, H) or zero-extend (BU, HU).
  - Register the result into resp_rdata at the LOAD→RESP edge.
- SW: IDLE→WRITE→RESP. mem_wd = latched wdata.
- SB/SH: IDLE→RMW_READ→WRITE→RESP.
  - In RMW_READ, capture mem_rd into a merge buffer.
  - In WRITE, mem_wd = buffer with the addressed lane replaced by wdata[7:0] or wdata[15:0]; all other bytes unchanged.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Memory-side outputs are Moore-decoded from state and latched registers only.
  - mem_we=1 only in WRITE.
  - mem_addr = latched word address in every state; it stays stable through RMW.
  - mem_wd=0 outside WRITE.
- resp_rdata and resp_err hold their values until the next response; they are meaningful only while resp_valid=1.
- Reset values:
  - state IDLE, with req_ready=1.
  - resp_valid, resp_err, resp_rdata, mem_we, mem_addr, mem_wd, and all latches = 0.

## Timing
- Latency in cycles from the accepting edge to the edge at which resp_valid is sampled:
  - error: 1
  - load or SW: 2
  - SB/SH: 3
- req_ready=1 only in IDLE, so at most one request is outstanding.
- The next request can be accepted on the edge after RESP. Throughput is one load per 3 cycles.
- Reset sampled in any state returns the unit to IDLE at that edge; the pending response is dropped.
  - A store reset while in RMW_READ never writes memory.
  - A write whose WRITE cycle coincides with the reset edge commits to memory, because mem_we was already high for that cycle.
- No combinational path from req_* to mem_* or resp_*.

## Structure
- lsu_pkg holds:
  - the state enum;
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - an is_legal/is_aligned helper function.
- Sub-module lsu_byte_lane, purely combinational:
  - inputs: word, offset, funct3, wdata;
  - outputs: extended load value and merged store word.
- FSM and latches live in lsu_rmw.

## Test plan
- Memory word 1 = 0x8765_4321:
  - LB at 0x7 → resp_rdata 0xFFFF_FF87, 2 cycles after acceptance, no mem_we.
  - LBU at 0x7 → 0x0000_0087.
- SB at 0x5 with wdata 0x0000_00AA on the same word → word 1 = 0x8765_AA21.
  - Exactly one mem_we pulse.
  - resp_valid at +3, resp_rdata=0.
- SH at 0x6 with wdata 0x1234_BEEF → word 1 = 0xBEEF_4321; a following LH at 0x6 → 0xFFFF_BEEF, and LHU → 0x0000_BEEF.
- Error requests, each → resp_err=1 at +1 with mem_we never asserted:
  - LW at 0x2.
  - SH at 0x3.
  - Load with funct3 011.
  - Store with funct3 100.
- Hold req_valid continuously with three loads queued by the driver → req_ready low while busy; each request accepted exactly once; responses in order at 3-cycle spacing.
- Assert rst_n=0 during RMW_READ of an SB → no mem_we, all outputs 0 next cycle, req_ready=1, memory unchanged.
